// File: rtl/jt12_pcm_interp_if.sv
// Bundle between the DAC register side and the PCM up-rater.
//
// Handshake: there is no ready. A sample is transferred on every clk where
// clk_en and pcm_wr are both high; pcm must be valid in that cycle. A tick is
// a rising edge of zero seen on clk_en cycles. On the output side out_stb is
// a one-clk qualifier: pcm_out carries a new sample in the cycle it is high
// and holds its value otherwise.
interface jt12_pcm_interp_if #(
  parameter int W = 9
);
  logic                clk_en;
  logic                zero;
  logic signed [W-1:0] pcm;
  logic                pcm_wr;
  logic                auto_en;
  logic [1:0]          rate_sel;
  logic signed [W-1:0] pcm_out;
  logic                out_stb;
  logic [1:0]          rate_det;

  modport master (
    output clk_en, zero, pcm, pcm_wr, auto_en, rate_sel,
    input  pcm_out, out_stb, rate_det
  );

  modport slave (
    input  clk_en, zero, pcm, pcm_wr, auto_en, rate_sel,
    output pcm_out, out_stb, rate_det
  );
endinterface

// File: rtl/jt12_pcm_interp.sv
// PCM up-rater: linearly interpolates sparse DAC writes up to the FM sample
// tick rate with a factor of 2^sh (sh = 0..MAXSH). The factor is forced by
// rate_sel or derived from the tick count between consecutive writes, and it
// is only latched on a write so an interval never changes rate halfway.
module jt12_pcm_interp #(
  parameter int W     = 9,
  parameter int MAXSH = 3,
  parameter int CNTW  = 4
) (
  input logic               clk,
  input logic               rst_n,
  jt12_pcm_interp_if.slave  bus
);
  // k must hold 2^MAXSH and k+1 without wrapping
  localparam int KW = MAXSH + 2;
  // |p1-p0| * k fits in W+1+MAXSH signed bits
  localparam int PW = W + 1 + MAXSH;
  localparam logic [1:0] MAX2 = 2'(MAXSH);

  logic                last_zero;
  logic signed [W-1:0] p0;
  logic signed [W-1:0] p1;
  logic [KW-1:0]       k;
  logic [CNTW-1:0]     cnt;
  logic [1:0]          sh;

  logic                tick;
  logic                wr;
  logic [1:0]          auto_sh;
  logic [1:0]          req_sh;
  logic [1:0]          new_sh;
  logic [KW-1:0]       kmax;
  logic [KW-1:0]       k_inc;
  logic [KW-1:0]       k_new;
  logic signed [W:0]   d;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] step;
  logic signed [W-1:0]  interp;

  assign tick = bus.clk_en & bus.zero & ~last_zero;
  assign wr   = bus.clk_en & bus.pcm_wr;

  // Spacing-to-factor map: the count of ticks since the previous write
  always_comb begin
    auto_sh = 2'd0;
    if (32'(cnt) >= 32'd8)      auto_sh = 2'd3;
    else if (32'(cnt) >= 32'd4) auto_sh = 2'd2;
    else if (32'(cnt) >= 32'd2) auto_sh = 2'd1;
  end

  assign req_sh = bus.auto_en ? auto_sh : bus.rate_sel;
  assign new_sh = (req_sh > MAX2) ? MAX2 : req_sh;

  // Interpolation datapath; the result always lies between p0 and p1
  assign kmax   = KW'(1) << sh;
  assign k_inc  = k + KW'(1);
  assign k_new  = (k_inc > kmax) ? kmax : k_inc;
  assign d      = {p1[W-1], p1} - {p0[W-1], p0};
  assign prod   = PW'(d) * PW'($signed({1'b0, k_new}));
  assign step   = prod >>> sh;
  assign interp = W'(PW'(p0) + step);

  assign bus.rate_det = sh;

  // Sample pair, step index, spacing counter and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_zero   <= 1'b0;
      p0          <= '0;
      p1          <= '0;
      k           <= '0;
      cnt         <= '0;
      sh          <= 2'd0;
      bus.pcm_out <= '0;
      bus.out_stb <= 1'b0;
    end else begin
      bus.out_stb <= 1'b0;
      if (bus.clk_en) last_zero <= bus.zero;
      if (wr) begin
        // a write wins over a coincident tick and restarts the interval
        p0  <= p1;
        p1  <= bus.pcm;
        k   <= '0;
        cnt <= '0;
        sh  <= new_sh;
        if (tick) begin
          bus.pcm_out <= p1;
          bus.out_stb <= 1'b1;
        end
      end else if (tick) begin
        k           <= k_new;
        bus.pcm_out <= interp;
        bus.out_stb <= 1'b1;
        if (cnt != {CNTW{1'b1}}) cnt <= cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_jt12_pcm_interp.sv
// Directed bench for the PCM up-rater: a vector table of writes and ticks
// with hand-computed outputs, plus short sequences for reset, coincident
// write/tick, gated writes and mid-interval reset. A second instance built
// with MAXSH=1 shares the stimulus to show factor clamping.
module tb_jt12_pcm_interp;
  localparam int W = 9;

  logic clk;
  logic rst_n;

  jt12_pcm_interp_if #(.W(W)) ifa ();
  jt12_pcm_interp_if #(.W(W)) ifb ();

  jt12_pcm_interp #(.W(W), .MAXSH(3), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  jt12_pcm_interp #(.W(W), .MAXSH(1), .CNTW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  assign ifb.clk_en   = ifa.clk_en;
  assign ifb.zero     = ifa.zero;
  assign ifb.pcm      = ifa.pcm;
  assign ifb.pcm_wr   = ifa.pcm_wr;
  assign ifb.auto_en  = ifa.auto_en;
  assign ifb.rate_sel = ifa.rate_sel;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int cap_out, cap_stb, cap_rate, cap_rate1;

  typedef struct {
    bit is_wr;
    int pcm;
    bit auto_en;
    int rs;
    int eo;
    int er;
    int er1;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit is_wr, int pcm, bit ae, int rs, int eo, int er, int er1);
    vec_t v;
    v.is_wr = is_wr; v.pcm = pcm; v.auto_en = ae; v.rs = rs;
    v.eo = eo; v.er = er; v.er1 = er1;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic capture();
    cap_out   = int'(ifa.pcm_out);
    cap_stb   = int'(ifa.out_stb);
    cap_rate  = int'(ifa.rate_det);
    cap_rate1 = int'(ifb.rate_det);
  endtask

  // one write on its own clk_en cycle, no tick
  task automatic do_wr(input int v, input bit ae, input int rs);
    @(negedge clk);
    ifa.clk_en = 1'b1; ifa.pcm_wr = 1'b1; ifa.pcm = W'(v);
    ifa.auto_en = ae; ifa.rate_sel = 2'(rs);
    @(posedge clk); #1 capture();
    @(negedge clk);
    ifa.pcm_wr = 1'b0;
  endtask

  // one rising edge of zero, then zero back low
  task automatic do_tick();
    @(negedge clk);
    ifa.clk_en = 1'b1; ifa.zero = 1'b1;
    @(posedge clk); #1 capture();
    @(negedge clk);
    ifa.zero = 1'b0;
    @(posedge clk);
  endtask

  task automatic tick_chk(input string name, input int eo);
    do_tick();
    chk({name, "_out"}, cap_out, eo);
    chk({name, "_stb"}, cap_stb, 1);
  endtask

  initial begin
    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifa.clk_en = 1'($urandom_range(0, 1));
      ifa.zero = 1'($urandom_range(0, 1));
      ifa.pcm = W'($urandom_range(0, 511));
      ifa.pcm_wr = 1'($urandom_range(0, 1));
      ifa.auto_en = 1'($urandom_range(0, 1));
      ifa.rate_sel = 2'($urandom_range(0, 3));
      @(posedge clk); #1 capture();
      chk($sformatf("rst%0d_out", i), cap_out, 0);
      chk($sformatf("rst%0d_stb", i), cap_stb, 0);
      chk($sformatf("rst%0d_rate", i), cap_rate, 0);
    end
    @(negedge clk);
    ifa.clk_en = 1'b1; ifa.zero = 1'b0; ifa.pcm_wr = 1'b0; ifa.pcm = '0;
    ifa.auto_en = 1'b0; ifa.rate_sel = 2'd0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick_chk($sformatf("idle%0d", i), 0);

    // forced x4: 0 -> 64
    add(1, 0, 0, 2, 0, 2, 1);
    add(1, 64, 0, 2, 0, 2, 1);
    add(0, 0, 0, 2, 16, 2, 0);
    add(0, 0, 0, 2, 32, 2, 0);
    add(0, 0, 0, 2, 48, 2, 0);
    add(0, 0, 0, 2, 64, 2, 0);
    add(0, 0, 0, 2, 64, 2, 0);
    // forced x8: 100 -> -100
    add(1, 100, 0, 3, 64, 3, 1);
    add(1, -100, 0, 3, 64, 3, 1);
    add(0, 0, 0, 3, 75, 3, 0);
    add(0, 0, 0, 3, 50, 3, 0);
    add(0, 0, 0, 3, 25, 3, 0);
    add(0, 0, 0, 3, 0, 3, 0);
    add(0, 0, 0, 3, -25, 3, 0);
    add(0, 0, 0, 3, -50, 3, 0);
    add(0, 0, 0, 3, -75, 3, 0);
    add(0, 0, 0, 3, -100, 3, 0);
    add(0, 0, 0, 3, -100, 3, 0);
    // full-scale steps -256 -> 255 -> -256
    add(1, -256, 0, 3, -100, 3, 1);
    add(1, 255, 0, 3, -100, 3, 1);
    add(0, 0, 0, 3, -193, 3, 0);
    add(0, 0, 0, 3, -129, 3, 0);
    add(0, 0, 0, 3, -65, 3, 0);
    add(0, 0, 0, 3, -1, 3, 0);
    add(0, 0, 0, 3, 63, 3, 0);
    add(0, 0, 0, 3, 127, 3, 0);
    add(0, 0, 0, 3, 191, 3, 0);
    add(0, 0, 0, 3, 255, 3, 0);
    add(1, -256, 0, 3, 255, 3, 1);
    add(0, 0, 0, 3, 191, 3, 0);
    add(0, 0, 0, 3, 127, 3, 0);
    // auto-detect: spacing 2, then 8, 2, 2, 1, 1, 4
    add(1, 0, 1, 0, 127, 1, 1);
    add(0, 0, 1, 0, -128, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 3, 1);
    add(0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 1, 0, 0, 3, 0);
    add(1, 8, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 1, 0, 8, 1, 0);
    add(1, 16, 1, 0, 8, 1, 1);
    add(0, 0, 1, 0, 12, 1, 0);
    add(0, 0, 1, 0, 16, 1, 0);
    add(1, 24, 1, 0, 16, 1, 1);
    add(0, 0, 1, 0, 20, 1, 0);
    add(1, 32, 1, 0, 20, 0, 0);
    add(0, 0, 1, 0, 32, 0, 0);
    add(1, 40, 1, 0, 32, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 40, 0, 0);
    add(1, 48, 1, 0, 40, 2, 1);
    add(0, 0, 1, 0, 42, 2, 0);

    foreach (vq[i]) begin
      if (vq[i].is_wr) begin
        do_wr(vq[i].pcm, vq[i].auto_en, vq[i].rs);
        chk($sformatf("v%0d_out", i), cap_out, vq[i].eo);
        chk($sformatf("v%0d_stb", i), cap_stb, 0);
        chk($sformatf("v%0d_rate", i), cap_rate, vq[i].er);
        chk($sformatf("v%0d_rate_m1", i), cap_rate1, vq[i].er1);
      end else begin
        do_tick();
        chk($sformatf("v%0d_out", i), cap_out, vq[i].eo);
        chk($sformatf("v%0d_stb", i), cap_stb, 1);
        chk($sformatf("v%0d_rate", i), cap_rate, vq[i].er);
      end
    end

    // write and tick in the same cycle: write wins, output is old p1
    do_wr(0, 0, 2);
    do_wr(64, 0, 2);
    tick_chk("co_pre", 16);
    @(negedge clk);
    ifa.zero = 1'b1; ifa.pcm_wr = 1'b1; ifa.pcm = W'(100);
    @(posedge clk); #1 capture();
    chk("co_out", cap_out, 64);
    chk("co_stb", cap_stb, 1);
    chk("co_rate", cap_rate, 2);
    @(negedge clk);
    ifa.zero = 1'b0; ifa.pcm_wr = 1'b0;
    @(posedge clk);
    tick_chk("co_k1", 73);
    tick_chk("co_k2", 82);

    // write strobe without clk_en is ignored
    @(negedge clk);
    ifa.clk_en = 1'b0; ifa.pcm_wr = 1'b1; ifa.pcm = W'(5);
    @(posedge clk); #1 capture();
    chk("gated_stb", cap_stb, 0);
    chk("gated_out", cap_out, 82);
    @(negedge clk);
    ifa.pcm_wr = 1'b0; ifa.clk_en = 1'b1;
    tick_chk("gated_k3", 91);

    // asynchronous reset in the middle of an x4 interval
    do_wr(0, 0, 2);
    do_wr(80, 0, 2);
    tick_chk("mr_k1", 20);
    tick_chk("mr_k2", 40);
    #3 rst_n = 1'b0;
    #1 capture();
    chk("mr_out", cap_out, 0);
    chk("mr_stb", cap_stb, 0);
    chk("mr_rate", cap_rate, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_wr(40, 0, 2);
    chk("mr_wr_rate", cap_rate, 2);
    tick_chk("mr_t1", 10);
    tick_chk("mr_t2", 20);
    tick_chk("mr_t3", 30);
    tick_chk("mr_t4", 40);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/jt12_pcm_interp.md
Name: jt12_pcm_interp

Overview:
Parametrised PCM up-rater for the YM2612 DAC path. It sits between the DAC register write strobe and the FM mixer. It raises the sparse CPU-written PCM stream to the FM sample tick ("zero") rate by linear interpolation, with a factor of x1/x2/x4/x8. The factor is either forced by a mode input or auto-detected from the write-to-tick spacing.

Parameters:
W, 9, signed PCM sample width (in and out).
MAXSH, 3, log2 of the largest interpolation factor (0..3); larger requested factors clamp to this.
CNTW, 4, width of the tick-spacing counter; saturates at 2^CNTW-1.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous and active-low.
clk_en  in  1  clock enable; all state advances only when high.
zero  in  1  FM sample tick level; a rising edge, sampled under clk_en, is one output tick.
pcm  in  W  signed sample from the DAC register.
pcm_wr  in  1  new sample strobe, qualified by clk_en.
auto_en  in  1  1 = auto-detect the factor; 0 = use rate_sel.
rate_sel  in  2  forced log2 factor when auto_en=0.
pcm_out  out  W  signed interpolated sample (registered).
out_stb  out  1  one-clk pulse when pcm_out updates.
rate_det  out  2  log2 factor currently in use.

Behaviour:
- Reset (rst_n low, async): pcm_out=0, out_stb=0, rate_det=0, p0=p1=0, k=0, cnt=0, last_zero=0.
- Edge detect: tick = clk_en & zero & !last_zero. last_zero <= zero whenever clk_en.
- Spacing counter cnt:
  - On tick without pcm_wr: cnt <= cnt+1, saturating at 2^CNTW-1.
  - On pcm_wr: cnt <= 0.
- Factor sh:
  - auto_en=0: sh = min(rate_sel, MAXSH). It takes effect at the next pcm_wr.
  - auto_en=1: at pcm_wr, the value of cnt before the clear maps as follows: >=8 -> 3, >=4 -> 2, >=2 -> 1, else 0, then clamp to MAXSH.
  - In both modes, sh and rate_det are latched only on pcm_wr, so the factor never changes mid-interval.
- Sample pair:
  - On pcm_wr: p0 <= p1, p1 <= pcm, k <= 0.
- Interpolation step (on each tick): k <= min(k+1, 2^sh). pcm_out <= p0 + ((p1-p0)*k_new >>> sh).
  - d = p1-p0 is computed at W+1 bits signed.
  - The product is W+1+MAXSH bits.
  - >>> is an arithmetic shift (floor toward -inf).
  - The result always lies between p0 and p1, so no saturation is needed.
  - out_stb=1 on the same clk pcm_out updates, 0 otherwise.
- Output timing: one sample interval of latency. After 2^sh ticks, pcm_out == p1 and holds at p1 until the next write (starvation hold).
- x1 (sh=0): the first tick after a write outputs p1 directly.
- Write and tick in the same clk_en cycle:
  - The write wins: the pair is updated, cnt <= 0, k <= 0.
  - pcm_out <= new p0 (the old p1), out_stb=1.
- pcm_wr without clk_en is ignored.
- Back-to-back writes with no tick in between: the intermediate sample is dropped from interpolation but still passes through p0.
- Reset asserted mid-interval returns all state to the reset values immediately. The first post-reset write interpolates from 0.
- clk_en low freezes all state, including edge detection.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> pcm_out=0, out_stb=0, rate_det=0. Release with no writes; ticks -> pcm_out stays 0.
- Forced x4: auto_en=0, rate_sel=2; write 0, then write 64. The next 5 ticks give pcm_out 16,32,48,64,64 (the 5th tick holds); rate_det=2.
- Forced x8, negative step: p1 goes from 100 to -100 with sh=3. Ticks give 75,50,25,0,-25,-50,-75,-100 (floor of -200*k/8 added to 100). A -256 to 255 step with W=9 never overflows.
- Auto-detect: auto_en=1; writes every 8 ticks, then every 2, then every 1. rate_det becomes 3, then 1, then 0, each changing at the write after the spacing change. MAXSH=1 build: the 8-tick spacing gives rate_det=1.
- Coincidence: pcm_wr and the tick rising edge in the same clk_en cycle -> pcm_out = old p1, out_stb=1, the interpolation index restarts.
- Mid-operation reset: assert rst_n low at k=2 of an x4 interval -> outputs clear asynchronously. The next write of 40 with x4 forced gives 10,20,30,40.
